// File: rtl/async_fifo_rd_ctrl.sv
// async_fifo_rd_ctrl: read-clock-domain controller of the asynchronous FIFO.
// Owns the binary/Gray read pointer and derives EMPTY and LEVEL from the
// synchronized Gray write pointer. Drives the memory read address and
// presents popped words through a registered valid/ready output stage.
// Optional feature macro: ASYNC_FIFO_RD_PTR_CHK_EN adds the sticky PTR_ERR
// output, which flags an impossible fill level.
module async_fifo_rd_ctrl #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH:0]   WPTR_SYNC,
    input  logic [DATA_WIDTH-1:0] MEM_DATA,
    input  logic                  OUT_READY,
    output logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic                  RD_EN,
    output logic [ADDR_WIDTH:0]   RPTR_GRAY,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   LEVEL,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID
`ifdef ASYNC_FIFO_RD_PTR_CHK_EN
    ,
    output logic                  PTR_ERR
`endif
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(1) << ADDR_WIDTH;

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_nxt;
    logic [PTR_W-1:0] wbin;
    logic             pop;

    // Gray-to-binary of the synchronized write pointer: bit i is the XOR of bits i and above
    always_comb begin
        wbin = '0;
        for (int unsigned i = 0; i < PTR_W; i++) begin
            wbin[i] = ^(WPTR_SYNC >> i);
        end
    end

    assign rbin_nxt  = rbin + PTR_W'(1);
    assign EMPTY     = (RPTR_GRAY == WPTR_SYNC);
    assign LEVEL     = wbin - rbin;
    assign pop       = !EMPTY && (!OUT_VALID || OUT_READY);
    assign RD_EN     = pop;
    assign RD_ADDR   = rbin[ADDR_WIDTH-1:0];

    // Read pointer and output stage: pop refills, a lone accept empties, a stall holds
    always_ff @(posedge CLK) begin
        if (RST) begin
            rbin      <= '0;
            RPTR_GRAY <= '0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
        end else if (pop) begin
            rbin      <= rbin_nxt;
            RPTR_GRAY <= rbin_nxt ^ (rbin_nxt >> 1);
            OUT_DATA  <= MEM_DATA;
            OUT_VALID <= 1'b1;
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

`ifdef ASYNC_FIFO_RD_PTR_CHK_EN
    // Sticky flag: a level above the memory depth means the pointers have diverged
    always_ff @(posedge CLK) begin
        if (RST) begin
            PTR_ERR <= 1'b0;
        end else if (LEVEL > DEPTH) begin
            PTR_ERR <= 1'b1;
        end
    end
`else
    // Pointer consistency checking is not built in this configuration.
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Self-checking bench for async_fifo_rd_ctrl (ADDR_WIDTH=3, DATA_WIDTH=8).
// The bench plays the write side: it fills a model memory, advances the
// Gray write pointer and pushes each written word to a scoreboard queue that
// is popped whenever the DUT's output stage hands a word to the consumer.
module tb_async_fifo_rd_ctrl;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW:0]   WPTR_SYNC;
    logic [DW-1:0] MEM_DATA;
    logic          OUT_READY;
    logic [AW-1:0] RD_ADDR;
    logic          RD_EN;
    logic [AW:0]   RPTR_GRAY;
    logic          EMPTY;
    logic [AW:0]   LEVEL;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
`ifdef ASYNC_FIFO_RD_PTR_CHK_EN
    logic          PTR_ERR;
`endif

    logic [DW-1:0] mem [8];
    logic [DW-1:0] sb_q [$];
    int            checks   = 0;
    int            failures = 0;
    int            wr_ptr   = 0;
    int            wcount   = 0;

    assign MEM_DATA = mem[RD_ADDR];

    always #5 CLK = ~CLK;

    async_fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WPTR_SYNC (WPTR_SYNC),
        .MEM_DATA  (MEM_DATA),
        .OUT_READY (OUT_READY),
        .RD_ADDR   (RD_ADDR),
        .RD_EN     (RD_EN),
        .RPTR_GRAY (RPTR_GRAY),
        .EMPTY     (EMPTY),
        .LEVEL     (LEVEL),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID)
`ifdef ASYNC_FIFO_RD_PTR_CHK_EN
        ,
        .PTR_ERR   (PTR_ERR)
`endif
    );

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = (AW+1)'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: settle inputs, note a handshake, step the edge, score the outcome
    task automatic tick();
        logic          acc;
        logic [DW-1:0] d;
        logic [AW:0]   g_prev;
        logic          rst_edge;
        logic [DW-1:0] exp_d;
        #1;
        acc      = OUT_VALID && OUT_READY;
        d        = OUT_DATA;
        g_prev   = RPTR_GRAY;
        rst_edge = RST;
        if (OUT_VALID === 1'b1 && OUT_READY === 1'b0)
            chk("stall_no_pop", RD_EN, 1'b0);
        @(posedge CLK);
        #1;
        if (!rst_edge)
            chk("gray_one_bit", 32'($countones(g_prev ^ RPTR_GRAY) <= 1), 1);
        if (acc === 1'b1) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                exp_d = sb_q.pop_front();
                chk("accepted_word", d, exp_d);
            end
        end
        if (OUT_VALID === 1'b1 && sb_q.size() != 0)
            chk("presented_word", OUT_DATA, sb_q[0]);
    endtask

    // Write-side model: fill memory, advance the Gray write pointer
    task automatic write_words(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = DW'(37 * wcount + 11);
            wcount++;
            mem[wr_ptr % 8] = d;
            sb_q.push_back(d);
            wr_ptr++;
        end
        WPTR_SYNC = gray(wr_ptr);
        #1;
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || OUT_VALID !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(sb_q.size() == 0 && OUT_VALID === 1'b0), 1);
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        WPTR_SYNC = '0;
        OUT_READY = 1'b0;
        wr_ptr    = 0;
        sb_q.delete();
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        RST       = 1'b1;
        WPTR_SYNC = '0;
        OUT_READY = 1'b0;

        // Reset state
        do_reset();
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_rptr_gray", RPTR_GRAY, 4'b0000);
        chk("rst_empty",     EMPTY,     1'b1);
        chk("rst_level",     LEVEL,     4'd0);
        chk("rst_rd_en",     RD_EN,     1'b0);
        chk("rst_out_data",  OUT_DATA,  8'h00);
`ifdef ASYNC_FIFO_RD_PTR_CHK_EN
        chk("rst_ptr_err",   PTR_ERR,   1'b0);
`endif

        // Three words, consumer always ready
        OUT_READY = 1'b1;
        write_words(3);
        chk("t2_wptr",  WPTR_SYNC, 4'b0010);
        chk("t2_level", LEVEL, 4'd3);
        chk("t2_empty", EMPTY, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_rd_en_burst", RD_EN, 1'b1);
            tick();
        end
        chk("t2_empty_after", EMPTY, 1'b1);
        chk("t2_rd_en_after", RD_EN, 1'b0);
        chk("t2_rptr_gray",   RPTR_GRAY, 4'b0010);
        chk("t2_level_after", LEVEL, 4'd0);
        drain(5, "t2_drain");

        // Full memory with a stalled consumer: exactly one pop
        do_reset();
        write_words(8);
        chk("t3_wptr",  WPTR_SYNC, 4'b1100);
        chk("t3_level_full", LEVEL, 4'd8);
        chk("t3_empty_full", EMPTY, 1'b0);
        chk("t3_rd_en_first", RD_EN, 1'b1);
        tick();
        chk("t3_valid", OUT_VALID, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("t3_level_hold", LEVEL, 4'd7);
            chk("t3_rd_en_stall", RD_EN, 1'b0);
            tick();
        end
        chk("t3_data_held", OUT_DATA, DW'(37 * 3 + 11));
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("t3_all_delivered", 32'(sb_q.size()), 0);
        chk("t3_valid_after", OUT_VALID, 1'b0);
        chk("t3_empty_after", EMPTY, 1'b1);
        chk("t3_rptr_gray", RPTR_GRAY, 4'b1100);

        // Wrap: 20 more words in chunks, read pointer passes 15 -> 0
        for (int c = 0; c < 5; c++) begin
            write_words(4);
            drain(20, "t4_drain");
        end
        chk("t4_rptr_gray_wrap", RPTR_GRAY, gray(28));
        chk("t4_empty", EMPTY, 1'b1);

        // Consumer toggling ready every cycle with five words available
        write_words(5);
        chk("t5_level", LEVEL, 4'd5);
        for (int i = 0; i < 10; i++) begin
            OUT_READY = (i % 2 == 1);
            tick();
        end
        chk("t5_all_delivered", 32'(sb_q.size()), 0);
        chk("t5_valid_after", OUT_VALID, 1'b0);
        chk("t5_rptr_gray", RPTR_GRAY, gray(33));

        // Mid-operation reset discards the held word
        OUT_READY = 1'b0;
        write_words(2);
        tick();
        chk("t6_valid_pre_rst", OUT_VALID, 1'b1);
        do_reset();
        chk("t6_valid_post_rst", OUT_VALID, 1'b0);
        chk("t6_rptr_post_rst", RPTR_GRAY, 4'b0000);

`ifdef ASYNC_FIFO_RD_PTR_CHK_EN
        // Illegal level raises a sticky error cleared only by reset
        WPTR_SYNC = gray(9);
        #1;
        chk("t7_level_illegal", LEVEL, 4'd9);
        chk("t7_ptr_err_pre", PTR_ERR, 1'b0);
        tick();
        chk("t7_ptr_err_set", PTR_ERR, 1'b1);
        WPTR_SYNC = gray(1);
        tick();
        tick();
        chk("t7_ptr_err_sticky", PTR_ERR, 1'b1);
        do_reset();
        chk("t7_ptr_err_clr", PTR_ERR, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
# async_fifo_rd_ctrl

Read-side controller of the asynchronous FIFO, in the read clock domain. It owns the read pointer (binary and Gray), derives EMPTY and fill level from the write pointer after the double-flop synchronizer has brought it into this domain, drives the FIFO memory read address, and presents popped words through a registered valid/ready output stage. Its Gray read pointer is the value the write-side synchronizer samples.

## Interface
- ADDR_WIDTH, 3, memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- DATA_WIDTH, 8, word width.

- CLK  in  1  read-domain clock.
- RST  in  1  synchronous, active-high reset.
- WPTR_SYNC  in  ADDR_WIDTH+1  Gray write pointer, already synchronized into CLK.
- MEM_DATA  in  DATA_WIDTH  memory read data; combinational from RD_ADDR.
- OUT_READY  in  1  consumer accepts OUT_DATA this cycle.
- RD_ADDR  out  ADDR_WIDTH  memory read address = rbin[ADDR_WIDTH-1:0].
- RD_EN  out  1  pop strobe (combinational).
- RPTR_GRAY  out  ADDR_WIDTH+1  registered Gray read pointer to write-side synchronizer.
- EMPTY  out  1  no unread word in memory.
- LEVEL  out  ADDR_WIDTH+1  words in memory not yet popped (output stage word excluded).
- OUT_DATA  out  DATA_WIDTH  registered output word.
- OUT_VALID  out  1  OUT_DATA holds a valid word.

## Operation
- Internal rbin (ADDR_WIDTH+1 bits). RPTR_GRAY is always gray(rbin) = rbin ^ (rbin >> 1), updated in the same register write as rbin.
- wbin = Gray-to-binary of WPTR_SYNC: wbin[MSB] = g[MSB], wbin[i] = wbin[i+1] ^ g[i].
- EMPTY = (RPTR_GRAY == WPTR_SYNC), combinational.
- LEVEL = (wbin - rbin) mod 2^(ADDR_WIDTH+1), combinational. Legal range 0..2^ADDR_WIDTH.
- pop = !EMPTY && (!OUT_VALID || OUT_READY). RD_EN = pop.
- On pop: rbin <= rbin+1, OUT_DATA <= MEM_DATA, OUT_VALID <= 1.
- Else if OUT_VALID && OUT_READY: OUT_VALID <= 0; OUT_DATA holds.
- Else: all state holds. OUT_DATA never changes while OUT_VALID=1 && OUT_READY=0.
- Pointer wrap: rbin rolls from 2^(ADDR_WIDTH+1)-1 to 0. The MSB toggles every pass through memory. Full depth is distinguished from empty by the MSB.

## Timing
- Reset (RST=1 at a CLK edge): rbin=0, RPTR_GRAY=0, OUT_VALID=0, OUT_DATA=0. Outputs then read EMPTY=(WPTR_SYNC==0) and LEVEL=wbin.
- Reset mid-operation discards the word in the output stage and all unread memory words. The write side must be reset in the same window.
- Latency: a WPTR_SYNC change that makes EMPTY=0 at cycle N gives pop at N and OUT_VALID=1 from N+1.
- Back-to-back throughput: with OUT_READY held 1 and EMPTY=0, one word per cycle.
- Simultaneous pop and consume: the new word replaces the old one. OUT_VALID stays 1 with no bubble.
- Last word (LEVEL=1) popped at N: EMPTY=1 at N+1, assuming WPTR_SYNC is unchanged.
- RPTR_GRAY changes at most one bit per clock. It is glitch-free because it is registered directly.
- WPTR_SYNC can advance by several counts between samples. LEVEL and EMPTY follow it with no special handling.

## Configuration
- ASYNC_FIFO_RD_PTR_CHK_EN defined: adds output PTR_ERR (1 bit, reset 0).
  - PTR_ERR is sticky. It is set one cycle after LEVEL > 2^ADDR_WIDTH.
  - It is cleared only by RST.
  - Pop behaviour is unaffected.
- Macro not defined: PTR_ERR port and its logic are absent.

## Test plan
- Reset with WPTR_SYNC=0 -> OUT_VALID=0, RPTR_GRAY=0, EMPTY=1, LEVEL=0, RD_EN=0.
- WPTR_SYNC=gray(3)=0b0010, OUT_READY=1 -> RD_EN high 3 consecutive cycles; OUT_DATA = mem[0],mem[1],mem[2] on successive cycles; then EMPTY=1; RPTR_GRAY=0b0010.
- WPTR_SYNC=gray(8)=0b1100 (full, ADDR_WIDTH=3), OUT_READY=0 -> exactly one pop. OUT_DATA=mem[0] holds; LEVEL=7. Then OUT_READY=1 for 8 cycles -> all 8 words delivered in order.
- Wrap: 20 words written and read in streams -> rbin passes 15->0. RPTR_GRAY sequence shows a single-bit change per pop; no word lost or duplicated.
- OUT_READY toggled 1/0 every cycle with 5 words available -> each word is presented until accepted. No pop occurs while OUT_VALID=1 and OUT_READY=0.
- With ASYNC_FIFO_RD_PTR_CHK_EN, rbin=0 and WPTR_SYNC=gray(9)=0b1101 -> PTR_ERR=1 next cycle, stays 1 after WPTR_SYNC returns legal, clears on RST.
